// File: rtl/seg_pkg.sv
// Shared constants and helpers for the scrolling 7-segment driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_V     = 7'b1100011;
  localparam logic [6:0] SEG_I     = 7'b1111011;
  localparam logic [6:0] SEG_X     = 7'b0001001;

  // Counter/index width that never collapses to zero bits.
  function automatic int seg_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scroll_mux_if.sv
// Message-buffer write port for seg_scroll_mux.
// Handshake: wr_en is the valid qualifier; the buffer is always ready, so every edge with wr_en=1 completes one write.
interface seg_wr_if #(
  parameter int MSG_LEN = 16
);
  import seg_pkg::*;

  localparam int AW = seg_width(MSG_LEN);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/seg_scroll_mux_tick_divider.sv
// Modulo-DIV counter with a one-cycle tick on its last count.
// clr wins over run and suppresses the tick of that cycle.
module tick_divider
  import seg_pkg::*;
#(
  parameter  int DIV = 4,
  localparam int CW  = seg_width(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_d, count_q;

  assign tick  = run && !clr && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/seg_scroll_mux.sv
// Scanning common-anode 7-segment driver with message buffer and scrolling window.
// Optional macro SEG_DIM_EN adds a 4-bit brightness input gating the anodes with a PWM.
module seg_scroll_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int MSG_LEN    = 16,
  parameter int SCAN_DIV   = 100000,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                scroll_en,
  input  logic                scroll_rst,
`ifdef SEG_DIM_EN
  input  logic [3:0]          brightness,
`endif
  seg_wr_if.slave             wr,
  output logic [6:0]          segmentos,
  output logic [N_DIGITS-1:0] anodos,
  output logic                scroll_wrap
);

  localparam int AW = seg_width(MSG_LEN);
  localparam int DW = seg_width(N_DIGITS);
  localparam int SW = seg_width(SCAN_DIV);
  localparam int RW = seg_width(SCROLL_DIV);
  localparam logic [AW-1:0] MSG_LAST  = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   MSG_LEN_X = (AW + 1)'(MSG_LEN);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);

  generate
    if (MSG_LEN < N_DIGITS) begin : g_bad_len
      $error("seg_scroll_mux: MSG_LEN must be >= N_DIGITS");
    end
  endgenerate

  logic [SW-1:0]       scan_cnt;
  logic                scan_tick;
  logic [RW-1:0]       unused_scroll_cnt;
  logic                scroll_tick;
  logic [6:0]          msg_d [MSG_LEN];
  logic [6:0]          msg_q [MSG_LEN];
  logic [DW-1:0]       digit_idx_d, digit_idx_q;
  logic [AW-1:0]       offset_d, offset_q;
  logic                scroll_wrap_d, scroll_wrap_q;
  logic [N_DIGITS-1:0] anodos_d, anodos_q;
  logic [6:0]          segmentos_d, segmentos_q;
  logic [AW:0]         char_sum;
  logic [AW-1:0]       char_idx;
  logic                drive;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (enable),
    .clr   (!enable),
    .count (scan_cnt),
    .tick  (scan_tick)
  );

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (enable && scroll_en),
    .clr   (scroll_rst),
    .count (unused_scroll_cnt),
    .tick  (scroll_tick)
  );

`ifdef SEG_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_q + 4'd1;
  end

  assign drive = enable && (scan_cnt != '0) && (pwm_q < brightness);
`else
  assign drive = enable && (scan_cnt != '0);
`endif

  always_comb begin
    msg_d = msg_q;
    if (wr.wr_en && (wr.wr_addr <= MSG_LAST)) begin
      msg_d[wr.wr_addr] = wr.wr_data;
    end

    digit_idx_d = digit_idx_q;
    if (!enable) begin
      digit_idx_d = '0;
    end else if (scan_tick) begin
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + 1'b1;
    end

    offset_d      = offset_q;
    scroll_wrap_d = 1'b0;
    if (scroll_rst) begin
      offset_d = '0;
    end else if (scroll_tick) begin
      offset_d      = (offset_q == MSG_LAST) ? '0 : offset_q + 1'b1;
      scroll_wrap_d = (offset_q == MSG_LAST);
    end

    // offset + digit never exceeds 2*MSG_LEN-2, so one subtract is a full modulo.
    char_sum = {1'b0, offset_q} + (AW + 1)'(digit_idx_q);
    if (char_sum >= MSG_LEN_X) char_sum = char_sum - MSG_LEN_X;
    char_idx = char_sum[AW-1:0];

    anodos_d    = '1;
    segmentos_d = SEG_BLANK;
    if (drive) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (DW'(i) == digit_idx_q) anodos_d[N_DIGITS-1-i] = 1'b0;
      end
      segmentos_d = msg_q[char_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= SEG_BLANK;
      digit_idx_q   <= '0;
      offset_q      <= '0;
      scroll_wrap_q <= 1'b0;
      anodos_q      <= '1;
      segmentos_q   <= SEG_BLANK;
    end else begin
      msg_q         <= msg_d;
      digit_idx_q   <= digit_idx_d;
      offset_q      <= offset_d;
      scroll_wrap_q <= scroll_wrap_d;
      anodos_q      <= anodos_d;
      segmentos_q   <= segmentos_d;
    end
  end

  assign anodos      = anodos_q;
  assign segmentos   = segmentos_q;
  assign scroll_wrap = scroll_wrap_q;

endmodule

// File: tb/tb_seg_scroll_mux.sv
// Self-checking bench for seg_scroll_mux (N_DIGITS=4, MSG_LEN=6, SCAN_DIV=4, SCROLL_DIV=64).
// A behavioural model queues the expected registered outputs each edge; directed checks cover the boundary cases.
module tb_seg_scroll_mux;
  import seg_pkg::*;

  localparam int N  = 4;
  localparam int ML = 6;
  localparam int SD = 4;
  localparam int RD = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic scroll_en = 1'b0;
  logic scroll_rst = 1'b0;
`ifdef SEG_DIM_EN
  logic [3:0] brightness = 4'd15;
`endif
  logic [6:0]   segmentos;
  logic [N-1:0] anodos;
  logic         scroll_wrap;

  always #5 clk = ~clk;

  seg_wr_if #(.MSG_LEN(ML)) wr_bus ();

  seg_scroll_mux #(
    .N_DIGITS   (N),
    .MSG_LEN    (ML),
    .SCAN_DIV   (SD),
    .SCROLL_DIV (RD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .scroll_en   (scroll_en),
    .scroll_rst  (scroll_rst),
`ifdef SEG_DIM_EN
    .brightness  (brightness),
`endif
    .wr          (wr_bus),
    .segmentos   (segmentos),
    .anodos      (anodos),
    .scroll_wrap (scroll_wrap)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];   // {anodos, segmentos, scroll_wrap}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_scan, m_idx, m_off, m_scroll, m_pwm;
  logic [6:0] m_msg [ML];

  task automatic model_reset();
    m_scan = 0; m_idx = 0; m_off = 0; m_scroll = 0; m_pwm = 0;
    for (int i = 0; i < ML; i++) m_msg[i] = SEG_BLANK;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic         drv;
    logic [N-1:0] an;
    logic [6:0]   sg;
    logic         wp;
    drv = enable && (m_scan != 0);
`ifdef SEG_DIM_EN
    drv = drv && (m_pwm < int'(brightness));
`endif
    an = '1;
    sg = SEG_BLANK;
    if (drv) begin
      an[N-1-m_idx] = 1'b0;
      sg = m_msg[(m_off + m_idx) % ML];
    end
    wp = enable && scroll_en && !scroll_rst && (m_scroll == RD-1) && (m_off == ML-1);
    exp_q.push_back({an, sg, wp});

    if (wr_bus.wr_en && (int'(wr_bus.wr_addr) < ML)) m_msg[int'(wr_bus.wr_addr)] = wr_bus.wr_data;
    if (!enable) begin
      m_scan = 0; m_idx = 0;
    end else if (m_scan == SD-1) begin
      m_scan = 0; m_idx = (m_idx + 1) % N;
    end else begin
      m_scan++;
    end
    if (scroll_rst) begin
      m_scroll = 0; m_off = 0;
    end else if (enable && scroll_en) begin
      if (m_scroll == RD-1) begin
        m_scroll = 0; m_off = (m_off + 1) % ML;
      end else begin
        m_scroll++;
      end
    end
    m_pwm = (m_pwm + 1) % 16;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check_out(input logic [11:0] e);
    chk("anodos",      32'(anodos),      32'(e[11:8]));
    chk("segmentos",   32'(segmentos),   32'(e[7:1]));
    chk("scroll_wrap", 32'(scroll_wrap), 32'(e[0]));
  endtask

  always @(negedge clk) begin
    if (rst_n && (exp_q.size() > 0)) check_out(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int addr, input logic [6:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = 3'(addr);
    wr_bus.wr_data = data;
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic wait_an(input string tag, input logic [N-1:0] pat);
    int k;
    k = 0;
    while ((anodos !== pat) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(anodos), 32'(pat));
  endtask

  // ---------------- directed sequence ----------------
  logic [N-1:0] pats [N];
  logic [6:0]   segs [N];
  int wraps;

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    pats = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    segs = '{SEG_D, SEG_A, SEG_V, SEG_I};

    // Reset values
    #12;
    chk("rst_anodos", 32'(anodos), 32'hF);
    chk("rst_segmentos", 32'(segmentos), 32'h7F);
    chk("rst_wrap", 32'(scroll_wrap), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Blank buffer scan
    enable = 1'b1;
    repeat (20) @(negedge clk);
    wait_an("blank_d0_anode", 4'b0111);
    chk("blank_d0_seg", 32'(segmentos), 32'(SEG_BLANK));

    // Message "DAVIDx", static window
    wr(0, SEG_D); wr(1, SEG_A); wr(2, SEG_V);
    wr(3, SEG_I); wr(4, SEG_D); wr(5, SEG_X);
    for (int d = 0; d < N; d++) begin
      wait_an("static_anode", pats[d]);
      chk("static_seg", 32'(segmentos), 32'(segs[d]));
    end

    // Six scroll steps: one wrap pulse on 5 -> 0
    scroll_en = 1'b1;
    wraps = 0;
    repeat (6*RD) begin
      @(negedge clk);
      if (scroll_wrap === 1'b1) wraps++;
    end
    chk("wrap_once", 32'(wraps), 32'd1);

    // scroll_rst coincident with the step out of offset 5
    wraps = 0;
    repeat (6*RD - 1) begin
      @(negedge clk);
      if (scroll_wrap === 1'b1) wraps++;
    end
    scroll_rst = 1'b1;
    @(negedge clk);
    scroll_rst = 1'b0;
    scroll_en  = 1'b0;
    if (scroll_wrap === 1'b1) wraps++;
    @(negedge clk);
    if (scroll_wrap === 1'b1) wraps++;
    chk("rst_no_wrap", 32'(wraps), 32'd0);
    wr(6, 7'h00);
    repeat (2*N*SD) @(negedge clk);
    wait_an("after_rst_anode", 4'b0111);
    chk("after_rst_seg", 32'(segmentos), 32'(SEG_D));

    // enable dropped mid-slot at digit 2, then re-enabled
    wait_an("digit2_anode", 4'b1101);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_anodos", 32'(anodos), 32'hF);
    chk("dis_seg", 32'(segmentos), 32'h7F);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_blank", 32'(anodos), 32'hF);
    @(negedge clk);
    chk("reen_digit0", 32'(anodos), 32'(4'b0111));
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-slot
    #2 rst_n = 1'b0;
    #1;
    chk("arst_anodos", 32'(anodos), 32'hF);
    chk("arst_segmentos", 32'(segmentos), 32'h7F);
    chk("arst_wrap", 32'(scroll_wrap), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (2*N*SD) @(negedge clk);
    wait_an("arst_blank_anode", 4'b0111);
    chk("arst_blank_seg", 32'(segmentos), 32'(SEG_BLANK));

`ifdef SEG_DIM_EN
    brightness = 4'd4;
    repeat (64) @(negedge clk);
    brightness = 4'd0;
    @(negedge clk);
    repeat (32) begin
      @(negedge clk);
      chk("dark_anodos", 32'(anodos), 32'hF);
    end
`endif

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
